keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
// - Scans the 7x5 calculator key matrix: drives ROW[6:0] active-low one row at a time, samples COL[4:0] (pulled up).
// - Debounces per full frame; rejects multi-key frames.
// - Delivers one key code per press to the calculator core over a valid/ready handshake.
// - Sits between the board pins (ROW/COL) and the calculator control FSM inside top.
// PARAMETERS
// - SCAN_DIV         50000  clock cycles each row is driven (1 ms @ 50 MHz); frame = 7*SCAN_DIV cycles
// - DEBOUNCE_FRAMES  4      consecutive identical frames required to accept a press or a release (>=1)
// - REPEAT_DELAY     250    frames held before first auto-repeat (KEYPAD_AUTOREPEAT_EN only)
// - REPEAT_RATE      50     frames between subsequent repeats (KEYPAD_AUTOREPEAT_EN only)
// PORTS
// - CLOCK_50   in   1  system clock, all logic on rising edge
// - reset      in   1  asynchronous, active-high; top derives it from BT_RESET
// - ROW        out  7  row drive, one-hot-low; 7'h7F = no row driven
// - COL        in   5  column sense, active-low, asynchronous to CLOCK_50
// - key_code   out  6  row*5+col, range 0..34
// - key_valid  out  1  key_code holds an untransferred key
// - key_ready  in   1  consumer accepts; transfer when key_valid && key_ready at a rising edge
// - key_down   out  1  a debounced key is currently held
// - overrun    out  1  1-cycle pulse: accepted press dropped because key_valid was still pending
// BEHAVIOUR
// - Reset values: ROW=7'h7F, key_code=0, key_valid=0, key_down=0, overrun=0; all counters 0, FSM=IDLE.
//   Reset mid-frame or mid-handshake discards everything immediately.
// - COL passes through a 2-FF synchronizer.
// - Scan:
//   - First cycle after reset release drives row 0 (ROW=7'h7E).
//   - Each row is held SCAN_DIV cycles; synced COL is sampled on the row's last cycle.
//   - Order 0..6, then wraps to 0.
//   - Row 6 sample closes the frame.
// - Frame classes:
//   - NONE: no zero seen.
//   - ONE(code): exactly one zero; code = row*5+col.
//   - MULTI: more than one zero; ghosting.
// - FSM, evaluated once per frame close:
//   - IDLE: ONE(c) -> PRESS_PEND, cand=c, cnt=1 (emit now if DEBOUNCE_FRAMES==1). Else stay.
//   - PRESS_PEND: ONE(cand) -> cnt++; on cnt==DEBOUNCE_FRAMES -> HELD, emit cand, key_down=1.
//     ONE(other) -> cand=other, cnt=1. NONE or MULTI -> IDLE.
//   - HELD: NONE -> RELEASE_PEND, cnt=1. ONE(cand) or MULTI -> stay. ONE(other) -> stay, ignored until release.
//   - RELEASE_PEND: NONE -> cnt++; on cnt==DEBOUNCE_FRAMES -> IDLE, key_down=0. Anything else -> HELD.
// - Emit: key_code/key_valid update on the frame-close edge, so latency = DEBOUNCE_FRAMES frames after first stable frame.
// - Handshake:
//   - key_valid stays high, key_code stable, until transfer; key_valid drops on the edge after transfer.
//   - Emit while key_valid high with no transfer: new code dropped, old kept, overrun pulses 1 cycle.
//   - Emit in the same cycle as a transfer: new code loaded, key_valid stays 1, no overrun.
// - Counters saturate; no wrap.
// CONFIGURATION
// - KEYPAD_AUTOREPEAT_EN defined:
//   - In HELD with ONE(cand), a frame counter runs from entry to HELD.
//   - Re-emits cand after REPEAT_DELAY frames, then every REPEAT_RATE frames; overrun rules apply.
//   - Counter clears on leaving HELD.
// - KEYPAD_AUTOREPEAT_EN undefined: exactly one emission per debounced press; repeat logic absent.
// TESTING (bench params: SCAN_DIV=4, DEBOUNCE_FRAMES=2, REPEAT_DELAY=3, REPEAT_RATE=2; frame=28 cycles)
// - Reset held: ROW=7F, key_valid=0. After release: ROW 7E,7D,7B,77,6F,5F,3F, 4 cycles each, then 7E again.
// - Press row2/col3 (COL=5'b10111 while ROW[2]=0), held 4 frames, key_ready=1:
//   key_valid at 2nd frame close with key_code=13; low next cycle; key_down=1; no further emission.
// - Bounce: press present on alternate frames only for 6 frames -> key_valid never asserts.
// - Row1/col0 + row4/col2 pressed together for 3 frames -> nothing emitted.
//   Release row1 -> key_code=22 after 2 frames.
// - key_ready=0: press 13, release, press 22 -> key_valid holds 13, overrun pulses once.
//   Raise key_ready -> 13 transferred, key_valid=0, 22 lost.
// - KEYPAD_AUTOREPEAT_EN, hold 13 for 10 frames, key_ready=1:
//   emissions at frame 2, +3 (frame 5), then frames 7 and 9; none after release.

Source files
------------

// File: rtl/keypad_scanner.sv
// 7x5 key-matrix scanner: row drive, 2-FF column sync, per-frame debounce, valid/ready key output.
// Define KEYPAD_AUTOREPEAT_EN to re-emit a held key after REPEAT_DELAY frames, then every REPEAT_RATE frames.
module keypad_scanner #(
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int REPEAT_DELAY    = 250,
    parameter int REPEAT_RATE     = 50
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    output logic [6:0] ROW,
    input  logic [4:0] COL,
    output logic [5:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_down,
    output logic       overrun
);
    typedef enum logic [1:0] {IDLE, PRESS_PEND, HELD, RELEASE_PEND} state_t;

    localparam int             DW       = $clog2(SCAN_DIV + 1);
    localparam logic [DW-1:0]  DIV_LAST = DW'(SCAN_DIV - 1);
    localparam int             CW       = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [CW-1:0]  DF_C     = CW'(DEBOUNCE_FRAMES);

    logic [4:0]    col_s1_q, col_s2_q;
    logic          active_q;
    logic [DW-1:0] div_q;
    logic [2:0]    row_q;
    logic [1:0]    acc_n_q;
    logic [5:0]    acc_code_q;
    state_t        state_q;
    logic [5:0]    cand_q;
    logic [CW-1:0] cnt_q;
    logic          down_q;
    logic [5:0]    code_q;
    logic          valid_q;
    logic          ovr_q;

    logic          sample, frame_close;
    logic [1:0]    row_n, tot_n;
    logic [2:0]    row_col, sum_n;
    logic [5:0]    row_code, tot_code;
    logic          f_none, f_one;
    logic [CW-1:0] cnt_inc;
    logic          press_emit, rep_emit, emit;

    assign ROW         = active_q ? ~(7'd1 << row_q) : 7'h7F;
    assign sample      = active_q && (div_q == DIV_LAST);
    assign frame_close = sample && (row_q == 3'd6);

    // Zero count is held at 0/1/2 where 2 stands for "more than one" (ghosting).
    always_comb begin
        row_n   = 2'd0;
        row_col = 3'd0;
        for (int c = 4; c >= 0; c--) begin
            if (!col_s2_q[c]) begin
                row_col = 3'(c);
                row_n   = (row_n == 2'd2) ? 2'd2 : row_n + 2'd1;
            end
        end
        row_code = 6'(row_q) * 6'd5 + 6'(row_col);
        sum_n    = {1'b0, acc_n_q} + {1'b0, row_n};
        tot_n    = (sum_n >= 3'd2) ? 2'd2 : sum_n[1:0];
        tot_code = (acc_n_q == 2'd0) ? row_code : acc_code_q;
    end

    assign f_none  = (tot_n == 2'd0);
    assign f_one   = (tot_n == 2'd1);
    assign cnt_inc = (cnt_q == DF_C) ? cnt_q : cnt_q + 1'b1;

    assign press_emit = frame_close && f_one &&
                        ((state_q == IDLE && DEBOUNCE_FRAMES == 1) ||
                         (state_q == PRESS_PEND && tot_code == cand_q && cnt_inc == DF_C));
    assign emit = press_emit || rep_emit;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            col_s1_q   <= 5'h1F;
            col_s2_q   <= 5'h1F;
            active_q   <= 1'b0;
            div_q      <= '0;
            row_q      <= 3'd0;
            acc_n_q    <= 2'd0;
            acc_code_q <= 6'd0;
        end else begin
            col_s1_q <= COL;
            col_s2_q <= col_s1_q;
            if (!active_q) begin
                active_q <= 1'b1;
                div_q    <= '0;
                row_q    <= 3'd0;
            end else if (div_q == DIV_LAST) begin
                div_q <= '0;
                row_q <= (row_q == 3'd6) ? 3'd0 : row_q + 3'd1;
            end else begin
                div_q <= div_q + 1'b1;
            end
            if (frame_close) begin
                acc_n_q    <= 2'd0;
                acc_code_q <= 6'd0;
            end else if (sample) begin
                acc_n_q    <= tot_n;
                acc_code_q <= tot_code;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cand_q  <= 6'd0;
            cnt_q   <= '0;
            down_q  <= 1'b0;
        end else if (frame_close) begin
            case (state_q)
                IDLE: if (f_one) begin
                    cand_q <= tot_code;
                    cnt_q  <= CW'(1);
                    if (DEBOUNCE_FRAMES == 1) begin
                        state_q <= HELD;
                        down_q  <= 1'b1;
                    end else begin
                        state_q <= PRESS_PEND;
                    end
                end
                PRESS_PEND: begin
                    if (f_one && tot_code == cand_q) begin
                        cnt_q <= cnt_inc;
                        if (cnt_inc == DF_C) begin
                            state_q <= HELD;
                            down_q  <= 1'b1;
                        end
                    end else if (f_one) begin
                        cand_q <= tot_code;
                        cnt_q  <= CW'(1);
                    end else begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                end
                // A different single key while held is ignored until a debounced release.
                HELD: if (f_none) begin
                    cnt_q <= CW'(1);
                    if (DEBOUNCE_FRAMES == 1) begin
                        state_q <= IDLE;
                        down_q  <= 1'b0;
                    end else begin
                        state_q <= RELEASE_PEND;
                    end
                end
                RELEASE_PEND: begin
                    if (f_none) begin
                        cnt_q <= cnt_inc;
                        if (cnt_inc == DF_C) begin
                            state_q <= IDLE;
                            down_q  <= 1'b0;
                        end
                    end else begin
                        state_q <= HELD;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // A new key collides with a pending one only if the consumer is not taking it this edge.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            code_q  <= 6'd0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ovr_q <= 1'b0;
            if (emit) begin
                if (valid_q && !key_ready) begin
                    ovr_q <= 1'b1;
                end else begin
                    code_q  <= tot_code;
                    valid_q <= 1'b1;
                end
            end else if (valid_q && key_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0] rep_q, rep_inc;
    logic          armed_q, rep_run, rep_hit;

    assign rep_inc  = (rep_q == {RW{1'b1}}) ? rep_q : rep_q + 1'b1;
    assign rep_hit  = armed_q ? (rep_inc == RW'(REPEAT_RATE)) : (rep_inc == RW'(REPEAT_DELAY));
    assign rep_run  = frame_close && (state_q == HELD) && f_one && (tot_code == cand_q);
    assign rep_emit = rep_run && rep_hit;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            rep_q   <= '0;
            armed_q <= 1'b0;
        end else if (state_q != HELD) begin
            rep_q   <= '0;
            armed_q <= 1'b0;
        end else if (rep_run) begin
            if (rep_hit) begin
                rep_q   <= '0;
                armed_q <= 1'b1;
            end else begin
                rep_q <= rep_inc;
            end
        end
    end
`else
    logic unused_rep;
    assign unused_rep = ^{32'(REPEAT_DELAY), 32'(REPEAT_RATE)};
    assign rep_emit   = 1'b0;
`endif

    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_down  = down_q;
    assign overrun   = ovr_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a combinational key matrix model drives COL from ROW.
module tb_keypad_scanner;
    localparam int SD = 4, DF = 2, RD = 3, RR = 2, FR = 7 * SD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  ROW;
    logic [4:0]  COL;
    logic [5:0]  key_code;
    logic        key_valid, key_ready, key_down, overrun;
    logic [34:0] keys = '0;

    always #5 clk = ~clk;

    always_comb begin
        COL = 5'h1F;
        for (int r = 0; r < 7; r++)
            for (int c = 0; c < 5; c++)
                if (!ROW[r] && keys[r*5+c]) COL[c] = 1'b0;
    end

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DF), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
        .CLOCK_50(clk), .reset(rst), .ROW(ROW), .COL(COL), .key_code(key_code),
        .key_valid(key_valid), .key_ready(key_ready), .key_down(key_down), .overrun(overrun)
    );

    int         n_chk = 0, n_err = 0, cyc = 0, n_emit = 0, n_ovr = 0;
    logic [5:0] last_code = '0;
    logic       kv_prev = 1'b0;
    int         emit_fr[$];

    always @(negedge clk) begin
        if (key_valid && !kv_prev) begin
            n_emit++;
            last_code = key_code;
            emit_fr.push_back(cyc / FR);
        end
        kv_prev = key_valid;
        if (overrun) n_ovr++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
    endtask

    task automatic goto_cyc(input int n);
        while (cyc < n) tick();
        #1;
    endtask

    task automatic goto_frame(input int k);
        goto_cyc(k * FR);
    endtask

    typedef struct { int n; logic [6:0] row; } row_vec_t;
    typedef struct { int key; int hold; int emits; logic [5:0] code; logic down; } press_vec_t;

    row_vec_t   rt[11];
    press_vec_t pt[5];
    int         F, base, bo, eb;
    int         roff[4];

    initial begin
        rt[0]  = '{0,  7'h7E}; rt[1] = '{3,  7'h7E}; rt[2]  = '{4,  7'h7D};
        rt[3]  = '{7,  7'h7D}; rt[4] = '{8,  7'h7B}; rt[5]  = '{12, 7'h77};
        rt[6]  = '{16, 7'h6F}; rt[7] = '{20, 7'h5F}; rt[8]  = '{24, 7'h3F};
        rt[9]  = '{27, 7'h3F}; rt[10] = '{28, 7'h7E};
        pt[0] = '{0,  3, 1, 6'd0,  1'b1};
        pt[1] = '{34, 2, 1, 6'd34, 1'b1};
        pt[2] = '{13, 4, 1, 6'd13, 1'b1};
        pt[3] = '{7,  1, 0, 6'd0,  1'b0};
        pt[4] = '{22, 3, 1, 6'd22, 1'b1};
        roff[0] = 2; roff[1] = 5; roff[2] = 7; roff[3] = 9;

        key_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_row",   ROW, 7'h7F);
        chk("rst_valid", key_valid, 0);
        chk("rst_down",  key_down, 0);
        chk("rst_ovr",   overrun, 0);
        chk("rst_code",  key_code, 0);
        rst = 1'b0;
        @(posedge clk);
        cyc = 0;
        #1;

        foreach (rt[i]) begin
            goto_cyc(rt[i].n);
            chk($sformatf("scan_row_c%0d", rt[i].n), ROW, rt[i].row);
        end

        // Single press of row2/col3, released after four frames.
        keys[13] = 1'b1;
        goto_frame(3);
        chk("p13_valid", key_valid, 1);
        chk("p13_code",  key_code, 13);
        chk("p13_down",  key_down, 1);
        tick(); #1;
        chk("p13_valid_drop", key_valid, 0);
        goto_frame(5);
        chk("p13_one_emit", n_emit, 1);
        keys = '0;
        goto_frame(6);
        chk("p13_down_rel1", key_down, 1);
        goto_frame(7);
        chk("p13_down_rel2", key_down, 0);
        F = 7;

        foreach (pt[i]) begin
            base = n_emit;
            keys = '0;
            keys[pt[i].key] = 1'b1;
            goto_frame(F + pt[i].hold);
            chk($sformatf("tab%0d_down", i), key_down, pt[i].down);
            keys = '0;
            goto_frame(F + pt[i].hold + 3);
            chk($sformatf("tab%0d_emits", i), n_emit - base, pt[i].emits);
            if (pt[i].emits > 0) chk($sformatf("tab%0d_code", i), last_code, pt[i].code);
            chk($sformatf("tab%0d_released", i), key_down, 0);
            F += pt[i].hold + 3;
        end

        // Bounce: key present on alternate frames only.
        base = n_emit;
        for (int i = 0; i < 6; i++) begin
            keys = '0;
            if (i % 2 == 0) keys[13] = 1'b1;
            goto_frame(F + i + 1);
        end
        chk("bounce_emits", n_emit - base, 0);
        chk("bounce_down",  key_down, 0);
        F += 6;

        // Two keys in different rows form a multi-key frame; release one to accept the other.
        base = n_emit;
        keys = '0;
        keys[5] = 1'b1;
        keys[22] = 1'b1;
        goto_frame(F + 3);
        chk("multi_emits", n_emit - base, 0);
        chk("multi_down",  key_down, 0);
        keys[5] = 1'b0;
        goto_frame(F + 5);
        chk("multi_then22_valid", key_valid, 1);
        chk("multi_then22_code",  key_code, 22);
        keys = '0;
        goto_frame(F + 8);
        chk("multi_emits_after", n_emit - base, 1);
        F += 8;

        // Consumer stalled: second press is dropped with a single overrun pulse.
        key_ready = 1'b0;
        base = n_emit;
        bo = n_ovr;
        keys[13] = 1'b1;
        goto_frame(F + 2);
        chk("ovr_first_valid", key_valid, 1);
        chk("ovr_first_code",  key_code, 13);
        keys = '0;
        goto_frame(F + 4);
        chk("ovr_rel_down", key_down, 0);
        keys[22] = 1'b1;
        goto_frame(F + 6);
        chk("ovr_pulse",      overrun, 1);
        chk("ovr_code_kept",  key_code, 13);
        chk("ovr_valid_kept", key_valid, 1);
        tick(); #1;
        chk("ovr_pulse_end", overrun, 0);
        keys = '0;
        goto_frame(F + 9);
        chk("ovr_count", n_ovr - bo, 1);
        chk("ovr_code_hold", key_code, 13);
        key_ready = 1'b1;
        tick(); #1;
        chk("ovr_xfer_valid", key_valid, 0);
        goto_frame(F + 10);
        chk("ovr_emits", n_emit - base, 1);
        chk("ovr_last_code", last_code, 13);
        F += 10;

        // Long hold of key 13, then release.
        base = n_emit;
        eb = emit_fr.size();
        keys[13] = 1'b1;
        goto_frame(F + 10);
        keys = '0;
        goto_frame(F + 13);
`ifdef KEYPAD_AUTOREPEAT_EN
        chk("rep_emits", n_emit - base, 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("rep_frame%0d", i),
                (eb + i < emit_fr.size()) ? emit_fr[eb + i] : -1, F + roff[i]);
`else
        chk("hold_emits", n_emit - base, 1);
        chk("hold_frame", (eb < emit_fr.size()) ? emit_fr[eb] : -1, F + roff[0]);
`endif
        chk("hold_released", key_down, 0);
        F += 13;

        // Asynchronous reset in the middle of a pending handshake.
        key_ready = 1'b0;
        keys[13] = 1'b1;
        goto_frame(F + 2);
        chk("mid_pre_valid", key_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_row",   ROW, 7'h7F);
        chk("mid_rst_valid", key_valid, 0);
        chk("mid_rst_down",  key_down, 0);
        chk("mid_rst_code",  key_code, 0);
        keys = '0;
        key_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        cyc = 0;
        #1;
        chk("mid_restart_row", ROW, 7'h7E);
        goto_frame(3);
        chk("mid_idle_valid", key_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
